// File: rtl/cs_video_pkg.sv
// cs_video_pkg -- shared types and constants for the video mixer/flash block.
// Holds the flash sequencer state enum, per-layer RGB weights and mix width.
package cs_video_pkg;

  // Flash sequencer states (HOLDOFF only reachable with CS_FLASH_LIMIT_EN)
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLASH   = 2'd1,
    ST_HOLDOFF = 2'd2
  } flash_state_e;

  // Channel width of the output and internal summing width (3 layers of <=15)
  localparam int CH_W  = 4;
  localparam int MIX_W = 6;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

  // Layer weights; saucer and rocket differ between mono and colour palettes
  localparam rgb_t W_STAR         = '{r: 4'd7,  g: 4'd7,  b: 4'd7};
  localparam rgb_t W_SAUCER_MONO  = '{r: 4'd7,  g: 4'd7,  b: 4'd7};
  localparam rgb_t W_SAUCER_COLOR = '{r: 4'd0,  g: 4'd15, b: 4'd15};
  localparam rgb_t W_ROCKET_MONO  = '{r: 4'd15, g: 4'd15, b: 4'd15};
  localparam rgb_t W_ROCKET_COLOR = '{r: 4'd15, g: 4'd15, b: 4'd0};

  // Sum the enabled layer weights of one channel and saturate at full scale
  function automatic logic [CH_W-1:0] mix_chan(
    input logic [2:0]      vid,
    input logic [CH_W-1:0] w_star,
    input logic [CH_W-1:0] w_saucer,
    input logic [CH_W-1:0] w_rocket
  );
    logic [MIX_W-1:0] sum;
    sum = (vid[0] ? {{(MIX_W-CH_W){1'b0}}, w_star}   : '0)
        + (vid[1] ? {{(MIX_W-CH_W){1'b0}}, w_saucer} : '0)
        + (vid[2] ? {{(MIX_W-CH_W){1'b0}}, w_rocket} : '0);
    return (sum > MIX_W'(15)) ? 4'hF : sum[CH_W-1:0];
  endfunction

endpackage

// File: rtl/cs_flash_seq.sv
// cs_flash_seq -- explosion detector and whole-frame inversion sequencer.
// Build option: define CS_FLASH_LIMIT_EN for the timed FLASH/HOLDOFF sequencing;
// without it, inversion simply follows the previous frame's explosion flag.
module cs_flash_seq
  import cs_video_pkg::*;
#(
  parameter int FLASH_FRAMES   = 1,
  parameter int HOLDOFF_FRAMES = 2
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic ce_pix,
  input  logic vs_rise,
  input  logic exp_pix,
  output logic inv
);

  // Reject out-of-range frame counts at elaboration
  generate
    if (FLASH_FRAMES < 1 || FLASH_FRAMES > 15 ||
        HOLDOFF_FRAMES < 0 || HOLDOFF_FRAMES > 15) begin : g_param_check
      $error("cs_flash_seq: FLASH_FRAMES must be 1..15, HOLDOFF_FRAMES 0..15");
    end
  endgenerate

  logic exp_seen_q, exp_seen_d;
  logic exp_now;

  // An explosion pixel in the vs_rise cycle still belongs to the ending frame
  assign exp_now = exp_seen_q | (ce_pix & exp_pix);

  // Explosion flag: collect over the frame, clear at frame start
  always_comb begin
    exp_seen_d = exp_now;
    if (vs_rise) begin
      exp_seen_d = 1'b0;
    end
  end

`ifdef CS_FLASH_LIMIT_EN

  localparam logic [3:0] FLASH_RELOAD = 4'(FLASH_FRAMES - 1);
  localparam logic [3:0] HOLD_RELOAD  = (HOLDOFF_FRAMES == 0) ? 4'd0 : 4'(HOLDOFF_FRAMES - 1);
  localparam bit         NO_HOLD      = (HOLDOFF_FRAMES == 0);

  flash_state_e state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;

  // Frame-rate FSM: only moves on vs_rise
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (vs_rise) begin
      case (state_q)
        ST_IDLE: begin
          if (exp_now) begin
            state_d = ST_FLASH;
            cnt_d   = FLASH_RELOAD;
          end
        end
        ST_FLASH: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else if (exp_now && NO_HOLD) begin
            cnt_d = FLASH_RELOAD;
          end else if (NO_HOLD) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end else begin
            state_d = ST_HOLDOFF;
            cnt_d   = HOLD_RELOAD;
          end
        end
        ST_HOLDOFF: begin
          // explosions are ignored here; exp_seen clears with this vs_rise
          if (cnt_q == 4'd0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // State, counter and explosion flag registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      exp_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      exp_seen_q <= exp_seen_d;
    end
  end

  assign inv = (state_q == ST_FLASH);

`else

  logic inv_q, inv_d;

  // Invert the next frame whenever the ending frame showed an explosion
  always_comb begin
    inv_d = inv_q;
    if (vs_rise) begin
      inv_d = exp_now;
    end
  end

  // Inversion and explosion flag registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      inv_q      <= 1'b0;
      exp_seen_q <= 1'b0;
    end else begin
      inv_q      <= inv_d;
      exp_seen_q <= exp_seen_d;
    end
  end

  assign inv = inv_q;

`endif

endmodule

// File: rtl/cs_video_ctrl.sv
// cs_video_ctrl -- layer mixer, palette select, frame counter and flash control.
// Build option: CS_FLASH_LIMIT_EN selects the timed flash sequencer in cs_flash_seq.
module cs_video_ctrl
  import cs_video_pkg::*;
#(
  parameter int FLASH_FRAMES   = 1,
  parameter int HOLDOFF_FRAMES = 2
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic       vsync,
  input  logic       hblank,
  input  logic       vblank,
  input  logic [3:0] video,
  input  logic       color_en,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b,
  output logic       inv,
  output logic [7:0] frame_cnt
);

  logic       vs_q, vs_d;
  logic       vs_rise;
  logic       mode_q, mode_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  rgb_t       rgb_q, rgb_d;
  rgb_t       w_saucer, w_rocket, mixed, pix;
  logic       inv_w;

  assign vs_rise = vsync & ~vs_q;

  cs_flash_seq #(
    .FLASH_FRAMES  (FLASH_FRAMES),
    .HOLDOFF_FRAMES(HOLDOFF_FRAMES)
  ) u_flash_seq (
    .clk_sys(clk_sys),
    .reset  (reset),
    .ce_pix (ce_pix),
    .vs_rise(vs_rise),
    .exp_pix(video[3]),
    .inv    (inv_w)
  );

  // Frame-rate state: edge detector, palette latch, frame counter
  always_comb begin
    vs_d        = vsync;
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    if (vs_rise) begin
      mode_d      = color_en;
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  // Pixel mixer: weight sum, saturate, invert, blank, then hold unless ce_pix
  always_comb begin
    w_saucer = mode_q ? W_SAUCER_COLOR : W_SAUCER_MONO;
    w_rocket = mode_q ? W_ROCKET_COLOR : W_ROCKET_MONO;
    mixed.r  = mix_chan(video[2:0], W_STAR.r, w_saucer.r, w_rocket.r);
    mixed.g  = mix_chan(video[2:0], W_STAR.g, w_saucer.g, w_rocket.g);
    mixed.b  = mix_chan(video[2:0], W_STAR.b, w_saucer.b, w_rocket.b);
    pix      = mixed ^ {3{{4{inv_w}}}};
    if (hblank | vblank) begin
      pix = '0;
    end
    rgb_d = rgb_q;
    if (ce_pix) begin
      rgb_d = pix;
    end
  end

  // Registers; vs_q tracks vsync even in reset so release never fakes an edge
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      vs_q        <= vsync;
      mode_q      <= 1'b0;
      frame_cnt_q <= 8'd0;
      rgb_q       <= '0;
    end else begin
      vs_q        <= vs_d;
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
      rgb_q       <= rgb_d;
    end
  end

  assign r         = rgb_q.r;
  assign g         = rgb_q.g;
  assign b         = rgb_q.b;
  assign inv       = inv_w;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_cs_video_ctrl.sv
// tb_cs_video_ctrl -- directed, table-driven bench for cs_video_ctrl.
// Expectations for the flash sequence follow CS_FLASH_LIMIT_EN when defined.
module tb_cs_video_ctrl;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic       ce_pix;
  logic       vsync;
  logic       hblank;
  logic       vblank;
  logic [3:0] video;
  logic       color_en;
  logic [3:0] r, g, b;
  logic       inv;
  logic [7:0] frame_cnt;

  int errors = 0;
  int checks = 0;

  cs_video_ctrl #(
    .FLASH_FRAMES  (2),
    .HOLDOFF_FRAMES(2)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ce_pix   (ce_pix),
    .vsync    (vsync),
    .hblank   (hblank),
    .vblank   (vblank),
    .video    (video),
    .color_en (color_en),
    .r        (r),
    .g        (g),
    .b        (b),
    .inv      (inv),
    .frame_cnt(frame_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    string       name;
    logic        color;
    logic [2:0]  vid;
    logic        hb;
    logic        vb;
    logic [11:0] exp_rgb;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl[NV];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // One frame boundary: a single vs_rise
  task automatic vs_pulse();
    vsync = 1'b1;
    tick();
    tick();
    vsync = 1'b0;
    tick();
  endtask

  // One ce_pix cycle followed by three idle cycles (ce every 4th clock)
  task automatic pixel(input logic [3:0] vid, input logic hb, input logic vb);
    video  = vid;
    hblank = hb;
    vblank = vb;
    ce_pix = 1'b1;
    tick();
    ce_pix = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic explode();
    video  = 4'b1000;
    ce_pix = 1'b1;
    tick();
    ce_pix = 1'b0;
    video  = 4'b0000;
    tick();
  endtask

  initial begin
    tbl[0]  = '{"mono_star",      1'b0, 3'b001, 1'b0, 1'b0, 12'h777};
    tbl[1]  = '{"mono_saucer",    1'b0, 3'b010, 1'b0, 1'b0, 12'h777};
    tbl[2]  = '{"mono_rocket",    1'b0, 3'b100, 1'b0, 1'b0, 12'hFFF};
    tbl[3]  = '{"mono_star_sauc", 1'b0, 3'b011, 1'b0, 1'b0, 12'hEEE};
    tbl[4]  = '{"mono_all_clamp", 1'b0, 3'b111, 1'b0, 1'b0, 12'hFFF};
    tbl[5]  = '{"mono_none",      1'b0, 3'b000, 1'b0, 1'b0, 12'h000};
    tbl[6]  = '{"mono_hblank",    1'b0, 3'b111, 1'b1, 1'b0, 12'h000};
    tbl[7]  = '{"col_saucer",     1'b1, 3'b010, 1'b0, 1'b0, 12'h0FF};
    tbl[8]  = '{"col_rocket",     1'b1, 3'b100, 1'b0, 1'b0, 12'hFF0};
    tbl[9]  = '{"col_star_sauc",  1'b1, 3'b011, 1'b0, 1'b0, 12'h7FF};
    tbl[10] = '{"col_sauc_rock",  1'b1, 3'b110, 1'b0, 1'b0, 12'hFFF};
    tbl[11] = '{"col_star_rock",  1'b1, 3'b101, 1'b0, 1'b0, 12'hFF7};
    tbl[12] = '{"col_vblank",     1'b1, 3'b100, 1'b0, 1'b1, 12'h000};
    tbl[13] = '{"col_star",       1'b1, 3'b001, 1'b0, 1'b0, 12'h777};

    reset = 1'b1; ce_pix = 1'b0; vsync = 1'b1; hblank = 1'b0; vblank = 1'b0;
    video = 4'b0000; color_en = 1'b0;
    tick(); tick(); tick();
    chk("reset_rgb", 16'({r, g, b}), 16'h000);
    chk("reset_inv", 16'(inv), 16'h0);
    chk("reset_frame_cnt", 16'(frame_cnt), 16'h00);
    // release with vsync high: no spurious frame
    reset = 1'b0;
    tick(); tick();
    chk("release_vsync_high", 16'(frame_cnt), 16'h00);
    vsync = 1'b0;
    tick();

    // mixer table
    for (int i = 0; i < NV; i++) begin
      color_en = tbl[i].color;
      vs_pulse();
      pixel({1'b0, tbl[i].vid}, tbl[i].hb, tbl[i].vb);
      chk(tbl[i].name, 16'({r, g, b}), 16'(tbl[i].exp_rgb));
    end

    // hold without ce_pix, then 7+7+15 clamp one ce_pix later
    color_en = 1'b0;
    vs_pulse();
    video = 4'b0111;
    tick(); tick(); tick();
    chk("hold_no_ce", 16'({r, g, b}), 16'(tbl[NV-1].exp_rgb));
    pixel(4'b0111, 1'b0, 1'b0);
    chk("mono_0111_clamp", 16'({r, g, b}), 16'hFFF);

    // colour selected mid-frame takes effect only at the next frame
    color_en = 1'b1;
    pixel(4'b0100, 1'b0, 1'b0);
    chk("mode_mid_frame", 16'({r, g, b}), 16'hFFF);
    vs_pulse();
    pixel(4'b0100, 1'b0, 1'b0);
    chk("mode_next_frame", 16'({r, g, b}), 16'hFF0);
    color_en = 1'b0;
    vs_pulse();

    // explosion sampled in the vs_rise cycle counts for the ending frame
    vsync = 1'b1; video = 4'b1000; ce_pix = 1'b1;
    tick();
    video = 4'b0000; ce_pix = 1'b0;
    tick();
    vsync = 1'b0;
    tick();
    chk("inv_f1", 16'(inv), 16'h1);
    pixel(4'b0011, 1'b0, 1'b0);
    chk("inv_xor_14", 16'({r, g, b}), 16'h111);
    pixel(4'b0000, 1'b0, 1'b0);
    chk("inv_xor_0", 16'({r, g, b}), 16'hFFF);
`ifdef CS_FLASH_LIMIT_EN
    vs_pulse();
    chk("inv_f2", 16'(inv), 16'h1);
    explode();
    vs_pulse();
    chk("inv_f3_holdoff", 16'(inv), 16'h0);
    vs_pulse();
    chk("inv_f4_holdoff", 16'(inv), 16'h0);
    vs_pulse();
    chk("inv_f5_idle", 16'(inv), 16'h0);
    explode();
    vs_pulse();
    chk("inv_f6_reflash", 16'(inv), 16'h1);
`else
    explode();
    vs_pulse();
    chk("inv_f2", 16'(inv), 16'h1);
    vs_pulse();
    chk("inv_f3", 16'(inv), 16'h0);
`endif

    // reset with vsync rising while flashing
    explode();
    vs_pulse();
    chk("inv_before_reset", 16'(inv), 16'h1);
    vsync = 1'b1; reset = 1'b1;
    tick();
    chk("reset_mid_flash_inv", 16'(inv), 16'h0);
    chk("reset_mid_flash_cnt", 16'(frame_cnt), 16'h00);
    chk("reset_mid_flash_rgb", 16'({r, g, b}), 16'h000);
    tick();
    reset = 1'b0;
    tick(); tick();
    chk("release_no_incr", 16'(frame_cnt), 16'h00);
    chk("release_inv", 16'(inv), 16'h0);
    vsync = 1'b0;
    tick();
    vs_pulse();
    chk("first_frame_after", 16'(frame_cnt), 16'h01);

    // frame counter wrap
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 254; i++) begin
      vs_pulse();
    end
    chk("frame_cnt_254", 16'(frame_cnt), 16'h00FE);
    vs_pulse();
    chk("frame_cnt_255", 16'(frame_cnt), 16'h00FF);
    vs_pulse();
    chk("frame_cnt_wrap", 16'(frame_cnt), 16'h0000);

    // blanking wins over inversion
    explode();
    vs_pulse();
    chk("inv_for_blank", 16'(inv), 16'h1);
    pixel(4'b0100, 1'b1, 1'b0);
    chk("hblank_inv", 16'({r, g, b}), 16'h000);
    pixel(4'b0001, 1'b0, 1'b0);
    chk("inv_star", 16'({r, g, b}), 16'h888);
    pixel(4'b0001, 1'b0, 1'b1);
    chk("vblank_inv", 16'({r, g, b}), 16'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cs_video_ctrl.md
CS_VIDEO_CTRL -- requirements
Module: cs_video_ctrl

Interface
REQ-001 Parameter FLASH_FRAMES, default 1, number of frames (1..15) inversion stays active once triggered.
REQ-002 Parameter HOLDOFF_FRAMES, default 2, number of frames (0..15) after a flash during which new triggers are ignored.
REQ-003 clk_sys input 1: single clock; all logic SHALL be on its rising edge.
REQ-004 reset input 1: synchronous, active-high reset.
REQ-005 ce_pix input 1: pixel enable; the pixel path advances only when high.
REQ-006 vsync, hblank, vblank inputs 1 each: raster timing from the game core.
REQ-007 video input 4: [0] star, [1] saucer, [2] rocket, [3] explosion flag.
REQ-008 color_en input 1: 0 = monochrome palette, 1 = colour palette (OSD option).
REQ-009 r, g, b outputs 4 each: mixed pixel colour.
REQ-010 inv output 1: whole-frame inversion active.
REQ-011 frame_cnt output 8: free-running frame counter.

Function
REQ-012 vs_rise SHALL equal vsync & ~vs_q, where vs_q is vsync registered every clk_sys, independent of ce_pix.
REQ-013 exp_seen SHALL set on any ce_pix cycle with video[3]=1 and clear on vs_rise; a video[3] sample in the vs_rise cycle counts toward the ending frame.
REQ-014 FSM states IDLE, FLASH, HOLDOFF SHALL change only on vs_rise; inv = (state==FLASH).
REQ-015 IDLE: if exp_seen then FLASH with cnt=FLASH_FRAMES-1; else stay IDLE.
REQ-016 FLASH: if cnt!=0 then decrement; else if exp_seen and HOLDOFF_FRAMES==0 then reload cnt and stay in FLASH; else go to HOLDOFF with cnt=HOLDOFF_FRAMES-1, or to IDLE if HOLDOFF_FRAMES==0.
REQ-017 HOLDOFF: decrement cnt; at cnt==0 go to IDLE; explosions seen during HOLDOFF SHALL be discarded.
REQ-018 color_en SHALL be sampled into mode_q only on vs_rise, so the palette never changes mid-frame.
REQ-019 Layer weights (R,G,B): star 7,7,7; saucer 7,7,7 in mono, 0,15,15 in colour; rocket 15,15,15 in mono, 15,15,0 in colour; each weight applies only when its video bit is 1.
REQ-020 Per channel, weights SHALL be summed at 6-bit width; a sum >15 SHALL clamp to 15.
REQ-021 The clamped value SHALL be XORed with {4{inv}}, then forced to 0 when hblank|vblank.
REQ-022 r, g, b SHALL register on ce_pix with 1 ce_pix latency; without ce_pix they hold.
REQ-023 frame_cnt SHALL increment on vs_rise and wrap from 255 to 0.

Reset
REQ-024 During reset: r, g, b = 0; inv = 0; frame_cnt = 0; state = IDLE; cnt = 0; exp_seen = 0; mode_q = 0.
REQ-025 During reset, vs_q SHALL load vsync, so releasing reset with vsync high causes no spurious vs_rise.
REQ-026 Reset SHALL take priority over vs_rise and ce_pix in the same cycle; reset asserted mid-flash SHALL drop inv on the next edge.

Configuration
REQ-027 Macro CS_FLASH_LIMIT_EN defined: the FLASH/HOLDOFF sequencing in REQ-014..REQ-017 applies.
REQ-028 CS_FLASH_LIMIT_EN undefined: no counter and no HOLDOFF state; at every vs_rise inv <= exp_seen; FLASH_FRAMES and HOLDOFF_FRAMES are ignored.

Structure
REQ-029 Package cs_video_pkg SHALL hold the FSM state enum, the layer weight constants and the mix width localparam.
REQ-030 The FSM, counter and exp_seen SHALL live in sub-module cs_flash_seq; the mixer stays in cs_video_ctrl.

Verification
REQ-031 Mono, video=0111, no blank, ce_pix every 4th cycle -> r=g=b=15 one ce_pix later (7+7+15 clamps to 15).
REQ-032 Colour set mid-frame, video=0100 -> output stays 15,15,15 until the next vs_rise, then reads 15,15,0.
REQ-033 Macro on, FLASH_FRAMES=2, HOLDOFF_FRAMES=2, video[3] pulsed in frames 0 and 2 -> inv high in frames 1-2, low in frames 3-4; the frame-2 pulse produces no flash.
REQ-034 Macro off, video[3] pulsed in frames 0 and 1 -> inv high in frames 1 and 2, low in frame 3.
REQ-035 Reset asserted with vsync high while in FLASH -> inv=0, frame_cnt=0, and no increment at release.
REQ-036 254 vs_rise pulses, then 2 more -> frame_cnt reads 254, 255, 0; with hblank=1, inv=1 and video=0100, r=g=b=0.
